lvds_tx_framer: RTL and testbench

- Serial transmit stage directly downstream of the parallella controller.
- Consumes the controller's start strobes, 5-bit command word and 32-bit data word, and serializes each into a framed single-lane bit stream for the LVDS output buffer.
- Returns per-channel busy flags that the controller samples as lvds_busy[1:0] before issuing the next start.

---
 rtl/lvds_tx_framer.sv | 148 ++++++++++++++
 tb/tb_lvds_tx_framer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lvds_tx_framer: frames command/data words as sync+type+payload+parity and  |
// | serializes them MSB first onto a single LVDS lane.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lvds_tx_framer #(
    parameter int         CLK_DIV    = 1,
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] SYNC_WORD  = 4'b1101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  start_i,
    input  logic [4:0]  command_i,
    input  logic [31:0] data_i,
    output logic [1:0]  busy_o,
    output logic        tx_o,
    output logic        tx_en_o,
    output logic        frame_done_o,
    output logic        drop_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_TYPE    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    localparam logic [7:0]  c_div_last = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_gap_last = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic [15:0] r_gap;
    logic [31:0] r_shift;
    logic        r_type;
    logic        r_parity;
    logic        r_done;
    logic        w_bit_end;
    logic        w_accept;
    logic        w_tx;
    logic        w_tx_en;

    assign w_bit_end = (r_div == c_div_last);
    assign w_accept  = (r_state == S_IDLE) && (start_i != 2'b00);

    always_comb begin
        w_next  = r_state;
        w_tx    = 1'b0;
        w_tx_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SYNC;
            end
            S_SYNC: begin
                w_tx    = SYNC_WORD[r_bit[1:0]];
                w_tx_en = 1'b1;
                if (w_bit_end && (r_bit == 6'd0)) w_next = S_TYPE;
            end
            S_TYPE: begin
                w_tx    = r_type;
                w_tx_en = 1'b1;
                if (w_bit_end) w_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                w_tx    = r_shift[31];
                w_tx_en = 1'b1;
                if (w_bit_end && (r_bit == 6'd0)) w_next = S_PARITY;
            end
            S_PARITY: begin
                w_tx    = r_parity;
                w_tx_en = 1'b1;
                if (w_bit_end) w_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (r_gap == c_gap_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_div    <= 8'd0;
            r_bit    <= 6'd0;
            r_gap    <= 16'd0;
            r_shift  <= 32'd0;
            r_type   <= 1'b0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state != S_IDLE) && (w_next == S_IDLE);

            if ((r_state == S_IDLE) || (r_state == S_GAP) || w_bit_end) r_div <= 8'd0;
            else                                                         r_div <= r_div + 8'd1;

            if (r_state == S_GAP) r_gap <= r_gap + 16'd1;
            else                  r_gap <= 16'd0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Command wins on a double start; payload is left-aligned so bit 31 always leads.
                        r_bit <= 6'd3;
                        if (start_i[0]) begin
                            r_shift  <= {command_i, 27'd0};
                            r_type   <= 1'b0;
                            r_parity <= ^command_i;
                        end else begin
                            r_shift  <= data_i;
                            r_type   <= 1'b1;
                            r_parity <= ~(^data_i);
                        end
                    end
                end
                S_SYNC: begin
                    if (w_bit_end && (r_bit != 6'd0)) r_bit <= r_bit - 6'd1;
                end
                S_TYPE: begin
                    if (w_bit_end) r_bit <= r_type ? 6'd31 : 6'd4;
                end
                S_PAYLOAD: begin
                    if (w_bit_end) begin
                        r_shift <= {r_shift[30:0], 1'b0};
                        if (r_bit != 6'd0) r_bit <= r_bit - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_o         = w_tx;
    assign tx_en_o      = w_tx_en;
    assign busy_o       = (r_state == S_IDLE) ? 2'b00 : (r_type ? 2'b10 : 2'b01);
    assign frame_done_o = r_done;
    assign drop_o       = (start_i != 2'b00) && ((r_state != S_IDLE) || (start_i == 2'b11));

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lvds_tx_framer: directed bench for lvds_tx_framer (CLK_DIV 1 and 3).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lvds_tx_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start_a, start_b;
    logic [4:0]  cmd_a, cmd_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  busy_a, busy_b;
    logic        tx_a, tx_b, en_a, en_b, done_a, done_b, drop_a, drop_b;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-built frames: sync 1101, type, payload, even parity.
    logic [37:0] c_cmd_frame  = {27'd0, 11'b1101_0_10011_1};
    logic [37:0] c_data_frame = {4'b1101, 1'b1, 32'hDEADBEEF, 1'b1};
    logic [37:0] c_cmd2_frame = {27'd0, 11'b1101_0_01100_0};

    always #5 clk = ~clk;

    lvds_tx_framer #(.CLK_DIV(1), .GAP_CYCLES(2), .SYNC_WORD(4'b1101)) u_dut_a (
        .clk(clk), .reset(reset), .start_i(start_a), .command_i(cmd_a), .data_i(data_a),
        .busy_o(busy_a), .tx_o(tx_a), .tx_en_o(en_a), .frame_done_o(done_a), .drop_o(drop_a)
    );

    lvds_tx_framer #(.CLK_DIV(3), .GAP_CYCLES(2), .SYNC_WORD(4'b1101)) u_dut_b (
        .clk(clk), .reset(reset), .start_i(start_b), .command_i(cmd_b), .data_i(data_b),
        .busy_o(busy_b), .tx_o(tx_b), .tx_en_o(en_b), .frame_done_o(done_b), .drop_o(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic t, input logic e, input logic [1:0] b,
                           input logic d, input logic dr);
        @(negedge clk);
        chk({tag, ".tx"},   {31'd0, tx_a},   {31'd0, t});
        chk({tag, ".en"},   {31'd0, en_a},   {31'd0, e});
        chk({tag, ".busy"}, {30'd0, busy_a}, {30'd0, b});
        chk({tag, ".done"}, {31'd0, done_a}, {31'd0, d});
        chk({tag, ".drop"}, {31'd0, drop_a}, {31'd0, dr});
        next_cycle();
    endtask

    // Accept cycle T on instance A: unit idle, start presented.
    task automatic accept_a(input logic [1:0] st, input logic [4:0] cmd, input logic [31:0] dat,
                            input logic exp_drop);
        start_a = st; cmd_a = cmd; data_a = dat;
        check_a("accept", 1'b0, 1'b0, 2'b00, 1'b0, exp_drop);
        start_a = 2'b00;
    endtask

    // Cycles T+1 .. T+nbits+3 (frame, two gap cycles, done cycle), optional start injection.
    task automatic frame_a(input string tag, input logic [37:0] bits, input int nbits,
                           input logic [1:0] exp_busy, input int inj_cyc, input logic [1:0] inj_val,
                           input logic [31:0] inj_data, input int ncheck);
        for (int c = 1; c <= nbits + 3 && c <= ncheck; c++) begin
            string t;
            t = $sformatf("%s.c%0d", tag, c);
            start_a = (c == inj_cyc) ? inj_val : 2'b00;
            cmd_a   = (c == inj_cyc) ? 5'b01100 : 5'($urandom);
            data_a  = (c == inj_cyc) ? inj_data : $urandom;
            if (c <= nbits)
                check_a(t, bits[nbits - c], 1'b1, exp_busy, 1'b0, c == inj_cyc);
            else if (c <= nbits + 2)
                check_a(t, 1'b0, 1'b0, exp_busy, 1'b0, c == inj_cyc);
            else
                check_a(t, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        start_a = 2'b00;
    endtask

    initial begin
        logic [37:0] fb;
        reset = 1'b1;
        start_a = 2'b00; cmd_a = 5'd0; data_a = 32'd0;
        start_b = 2'b00; cmd_b = 5'd0; data_b = 32'd0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst.busy_a", {30'd0, busy_a}, 32'd0);
        chk("rst.tx_a",   {31'd0, tx_a},   32'd0);
        chk("rst.en_a",   {31'd0, en_a},   32'd0);
        chk("rst.done_a", {31'd0, done_a}, 32'd0);
        chk("rst.busy_b", {30'd0, busy_b}, 32'd0);
        chk("rst.en_b",   {31'd0, en_b},   32'd0);
        next_cycle();
        reset = 1'b0;
        check_a("idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Command frame 10011.
        accept_a(2'b01, 5'b10011, 32'h0, 1'b0);
        frame_a("cmd", c_cmd_frame, 11, 2'b01, -1, 2'b00, 32'h0, 99);

        // Data frame DEADBEEF.
        accept_a(2'b10, 5'd0, 32'hDEADBEEF, 1'b0);
        frame_a("data", c_data_frame, 38, 2'b10, -1, 2'b00, 32'h0, 99);

        // Double start: command wins with a drop; data re-presented on done cycle.
        accept_a(2'b11, 5'b10011, 32'h12345678, 1'b1);
        frame_a("dbl", c_cmd_frame, 11, 2'b01, 14, 2'b10, 32'hDEADBEEF, 99);
        frame_a("b2b", c_data_frame, 38, 2'b10, -1, 2'b00, 32'h0, 99);

        // Start while busy at T+5.
        accept_a(2'b01, 5'b10011, 32'h0, 1'b0);
        frame_a("busy", c_cmd_frame, 11, 2'b01, 5, 2'b01, 32'h0, 99);

        // Reset at T+6 of a data frame.
        accept_a(2'b10, 5'd0, 32'hDEADBEEF, 1'b0);
        frame_a("pre_rst", c_data_frame, 38, 2'b10, -1, 2'b00, 32'h0, 5);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_a("post_rst", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_a("post_rst2", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        accept_a(2'b01, 5'b01100, 32'h0, 1'b0);
        frame_a("cmd2", c_cmd2_frame, 11, 2'b01, -1, 2'b00, 32'h0, 99);

        // CLK_DIV=3 instance: 11 bits x 3 cycles, gap 2, done at T+36.
        fb = c_cmd_frame;
        start_b = 2'b01; cmd_b = 5'b10011;
        @(negedge clk);
        chk("div3.accept.busy", {30'd0, busy_b}, 32'd0);
        next_cycle();
        start_b = 2'b00; cmd_b = 5'b00000;
        for (int c = 1; c <= 36; c++) begin
            string t;
            t = $sformatf("div3.c%0d", c);
            @(negedge clk);
            if (c <= 33) begin
                chk({t, ".tx"}, {31'd0, tx_b}, {31'd0, fb[10 - (c - 1) / 3]});
                chk({t, ".en"}, {31'd0, en_b}, 32'd1);
                chk({t, ".busy"}, {30'd0, busy_b}, 32'd1);
                chk({t, ".done"}, {31'd0, done_b}, 32'd0);
            end else if (c <= 35) begin
                chk({t, ".en"}, {31'd0, en_b}, 32'd0);
                chk({t, ".busy"}, {30'd0, busy_b}, 32'd1);
                chk({t, ".done"}, {31'd0, done_b}, 32'd0);
            end else begin
                chk({t, ".busy"}, {30'd0, busy_b}, 32'd0);
                chk({t, ".done"}, {31'd0, done_b}, 32'd1);
                chk({t, ".drop"}, {31'd0, drop_b}, 32'd0);
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
